// File: rtl/aes_round_sequencer_if.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer_if
//   Request/response handshake bundle between the top-level request logic
//   and the AES round sequencer.
//
//   Request side : in_valid, in_ready, mode (0 enc / 1 dec), block_in[127:0]
//   Response side: out_valid, out_ready, block_out[127:0]
//
//   master - the requester/consumer (drives requests, accepts results)
//   slave  - the sequencer
// ---------------------------------------------------------------------------
interface aes_round_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [127:0] block_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] block_out;

    modport master (
        output in_valid, mode, block_in, out_ready,
        input  in_ready, out_valid, block_out
    );

    modport slave (
        input  in_valid, mode, block_in, out_ready,
        output in_ready, out_valid, block_out
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//   Iterative controller for one shared AES round datapath. A block and its
//   direction are accepted over the handshake bus, whitened with the first
//   round key, then pushed through the external round unit once per cycle
//   for NR cycles. The finished block is held on the bus until consumed.
//
// Parameters
//   NR  number of rounds (10, 12 or 14)
//   NK  key length in 32-bit words, must satisfy NK + 6 == NR
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   bus           handshake bundle (slave side): in_valid/in_ready/mode/
//                 block_in request, out_valid/out_ready/block_out response
//   expanded_key  all round keys, rk(0) in the most significant 128 bits
//   rnd_state     state presented to the round unit
//   rnd_key       round key for the current round
//   rnd_final     last round: round unit skips (Inv)MixColumns
//   rnd_inverse   latched direction, selects inverse round operations
//   rnd_result    combinational result from the round unit
//   busy          high whenever a block is in flight or waiting to be taken
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NR = 14,
    parameter int NK = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    aes_round_sequencer_if.slave      bus,
    input  logic [128*(NR+1)-1:0]     expanded_key,
    output logic [127:0]              rnd_state,
    output logic [127:0]              rnd_key,
    output logic                      rnd_final,
    output logic                      rnd_inverse,
    input  logic [127:0]              rnd_result,
    output logic                      busy
);

    localparam int            DATA_W = 128;
    localparam int            KW     = DATA_W * (NR + 1);
    localparam int            CW     = $clog2(NR + 1);
    localparam logic [CW-1:0] LAST   = CW'(NR);

    if ((NK + 6 != NR) || !(NR == 10 || NR == 12 || NR == 14)) begin : g_param_check
        $error("aes_round_sequencer: illegal NR/NK combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } state_t;

    state_t              r_fsm;
    state_t              w_fsm_nxt;
    logic [DATA_W-1:0]   r_state;
    logic [CW-1:0]       r_round_cnt;
    logic                r_mode;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_load;
    logic                w_step;
    logic                w_final;
    logic [CW-1:0]       w_load_idx;
    logic [CW-1:0]       w_rnd_idx;
    logic [DATA_W-1:0]   w_load_key;
    logic [DATA_W-1:0]   w_rk [NR+1];

    // Unpack the flat key bus so rk(i) is a plain array element.
    for (genvar gi = 0; gi <= NR; gi++) begin : g_rk
        assign w_rk[gi] = expanded_key[KW-1-DATA_W*gi -: DATA_W];
    end

    // Whitening key: decryption starts from the last round key.
    assign w_load_idx = bus.mode ? LAST : '0;
    assign w_load_key = w_rk[w_load_idx];

    // Decryption walks the key schedule backwards.
    assign w_rnd_idx  = r_mode ? (LAST - r_round_cnt) : r_round_cnt;

    // -----------------------------------------------------------------------
    // Control FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM: next state and handshake decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_final     = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load    = 1'b1;
                    w_fsm_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                w_step  = 1'b1;
                w_final = (r_round_cnt == LAST);
                if (w_final) begin
                    w_fsm_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                // Result slot frees up the same cycle it is consumed, so a
                // waiting request can be loaded without an idle bubble.
                if (bus.out_ready) begin
                    w_in_ready = 1'b1;
                    if (bus.in_valid) begin
                        w_load    = 1'b1;
                        w_fsm_nxt = S_ROUND;
                    end else begin
                        w_fsm_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Cipher state, round counter and latched direction
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= '0;
            r_round_cnt <= '0;
            r_mode      <= 1'b0;
        end else if (w_load) begin
            r_state     <= bus.block_in ^ w_load_key;
            r_mode      <= bus.mode;
            r_round_cnt <= CW'(1);
        end else if (w_step) begin
            r_state <= rnd_result;
            // Counter parks at NR rather than stepping past the last round.
            if (!w_final) begin
                r_round_cnt <= r_round_cnt + CW'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.block_out = r_state;
    assign rnd_state     = r_state;
    assign rnd_key       = w_rk[w_rnd_idx];
    assign rnd_final     = w_final;
    assign rnd_inverse   = r_mode;
    assign busy          = (r_fsm != S_IDLE);

endmodule
